pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register that replaces the fixed-field, free-running inter-stage latches between ID/EX, EX/MEM and MEM/WB.
- Carries a packed datapath bus and a packed control bus across one clock, adding:
  - a valid/ready handshake, so stalls are expressed as back-pressure;
  - a synchronous flush that inserts a bubble;
  - an optional skid entry, so the upstream ready is driven by a register rather than combinationally.
- Ctrl bits are forced to zero in every bubble, so a stalled or flushed slot can never assert regWrite, memWrite or jump downstream.

---
 rtl/pipe_stage_reg.sv | 168 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Purpose : one pipeline register between CPU stages (ID/EX, EX/MEM, MEM/WB) with handshake, flush and bubble ctrl zeroing.
// Latency : a word accepted at edge N appears on out_* in cycle N+1; one word per cycle while out_ready=1.
// Backpr. : out_ready=0 stalls the held word; with PIPE_STAGE_SKID_EN one extra word is absorbed and in_ready is registered.
//
// Ports:
//   clk, reset (async, active-low), flush (sync, highest priority)
//   in_valid/in_ready/in_data/in_ctrl      upstream side
//   out_valid/out_ready/out_data/out_ctrl  downstream side (out_ctrl is zero whenever out_valid=0)
//   occupancy                              number of held entries (0..2 with skid, 0..1 without)
// Build option: define PIPE_STAGE_SKID_EN to add the skid entry S and a registered in_ready.

module pipe_stage_reg #(
   parameter int DATA_W              = 32,
   parameter int CTRL_W              = 16,
   parameter int CLEAR_DATA_ON_FLUSH = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   // main entry M, always the one driving out_*
   logic              r_m_vld;
   logic [DATA_W-1:0] r_m_data;
   logic [CTRL_W-1:0] r_m_ctrl;

   logic w_accept;
   logic w_issue;
   logic w_s_vld;

   assign w_accept = in_valid & in_ready;
   assign w_issue  = r_m_vld & out_ready;

   assign out_valid = r_m_vld;
   assign out_data  = r_m_data;
   // gate ctrl so a bubble can never carry regWrite/memWrite/jump downstream
   assign out_ctrl  = r_m_vld ? r_m_ctrl : '0;
   assign occupancy = {1'b0, r_m_vld} + {1'b0, w_s_vld};

`ifdef PIPE_STAGE_SKID_EN

   logic              r_s_vld;
   logic [DATA_W-1:0] r_s_data;
   logic [CTRL_W-1:0] r_s_ctrl;
   logic              r_in_rdy;

   logic w_m_load_in;
   logic w_m_load_s;
   logic w_m_clr;
   logic w_s_load;
   logic w_s_clr;
   logic w_s_vld_nxt;

   assign w_s_vld  = r_s_vld;
   // registered ready: low while S holds a word, low throughout reset
   assign in_ready = r_in_rdy;

   always_comb begin
      w_m_load_in = 1'b0;
      w_m_load_s  = 1'b0;
      w_m_clr     = 1'b0;
      w_s_load    = 1'b0;
      w_s_clr     = 1'b0;
      if (r_s_vld) begin
         // in_ready is low here, so no accept can coincide with S draining
         if (w_issue) begin
            w_m_load_s = 1'b1;
            w_s_clr    = 1'b1;
         end
      end else if (w_accept) begin
         if (!r_m_vld || w_issue) begin
            w_m_load_in = 1'b1;
         end else begin
            w_s_load = 1'b1;
         end
      end else if (w_issue) begin
         w_m_clr = 1'b1;
      end
      w_s_vld_nxt = (r_s_vld & ~w_s_clr) | w_s_load;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_vld  <= 1'b0;
         r_m_data <= '0;
         r_m_ctrl <= '0;
         r_s_vld  <= 1'b0;
         r_s_data <= '0;
         r_s_ctrl <= '0;
         r_in_rdy <= 1'b0;
      end else if (flush) begin
         // any issue this cycle has already completed downstream; accept is dropped
         r_m_vld  <= 1'b0;
         r_m_ctrl <= '0;
         r_s_vld  <= 1'b0;
         r_s_ctrl <= '0;
         r_in_rdy <= 1'b1;
         if (CLEAR_DATA_ON_FLUSH != 0) begin
            r_m_data <= '0;
            r_s_data <= '0;
         end
      end else begin
         if (w_m_load_in) begin
            r_m_vld  <= 1'b1;
            r_m_data <= in_data;
            r_m_ctrl <= in_ctrl;
         end else if (w_m_load_s) begin
            r_m_vld  <= 1'b1;
            r_m_data <= r_s_data;
            r_m_ctrl <= r_s_ctrl;
         end else if (w_m_clr) begin
            r_m_vld  <= 1'b0;
         end
         if (w_s_load) begin
            r_s_vld  <= 1'b1;
            r_s_data <= in_data;
            r_s_ctrl <= in_ctrl;
         end else if (w_s_clr) begin
            r_s_vld  <= 1'b0;
         end
         r_in_rdy <= ~w_s_vld_nxt;
      end
   end

`else

   // r_live keeps in_ready low during reset and up to the first edge after release
   logic r_live;

   assign w_s_vld  = 1'b0;
   assign in_ready = r_live & (~r_m_vld | out_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_live   <= 1'b0;
         r_m_vld  <= 1'b0;
         r_m_data <= '0;
         r_m_ctrl <= '0;
      end else begin
         r_live <= 1'b1;
         if (flush) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= '0;
            if (CLEAR_DATA_ON_FLUSH != 0) begin
               r_m_data <= '0;
            end
         end else if (w_accept) begin
            r_m_vld  <= 1'b1;
            r_m_data <= in_data;
            r_m_ctrl <= in_ctrl;
         end else if (w_issue) begin
            r_m_vld  <= 1'b0;
         end
      end
   end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table of streaming/bubble/flush vectors plus hand-written
// back-pressure, flush-when-full and mid-stream reset sequences for the built variant.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [15:0] in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] out_ctrl;
   logic [1:0]  occupancy;

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CLEAR_DATA_ON_FLUSH(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] d;
      logic [15:0] c;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [31:0] e_d;
      logic [15:0] e_c;
      logic [1:0]  e_occ;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                        input logic [15:0] c, input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
   endtask

   // advance one edge and land 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic ov, input logic [31:0] d,
                          input logic [15:0] c, input logic [1:0] occ);
      chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, ov});
      chk({nm, ".data"},  out_data, d);
      chk({nm, ".ctrl"},  {16'd0, out_ctrl}, {16'd0, c});
      chk({nm, ".occ"},   {30'd0, occupancy}, {30'd0, occ});
   endtask

   initial begin
      // streaming, bubble ctrl and flush with out_ready=1: identical for both builds
      tbl[0] = '{1'b0, 1'b1, 32'h1,    16'h0011, 1'b1, 1'b1, 1'b1, 32'h1,    16'h0011, 2'd1};
      tbl[1] = '{1'b0, 1'b1, 32'h2,    16'h0022, 1'b1, 1'b1, 1'b1, 32'h2,    16'h0022, 2'd1};
      tbl[2] = '{1'b0, 1'b1, 32'h3,    16'h0033, 1'b1, 1'b1, 1'b1, 32'h3,    16'h0033, 2'd1};
      tbl[3] = '{1'b0, 1'b1, 32'h4,    16'h0044, 1'b1, 1'b1, 1'b1, 32'h4,    16'h0044, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 32'hCAFE, 16'hFFFF, 1'b1, 1'b1, 1'b1, 32'hCAFE, 16'hFFFF, 2'd1};
      tbl[5] = '{1'b0, 1'b0, 32'hDEAD, 16'h1234, 1'b1, 1'b1, 1'b0, 32'hCAFE, 16'h0000, 2'd0};
      tbl[6] = '{1'b0, 1'b0, 32'hBEEF, 16'h4321, 1'b1, 1'b1, 1'b0, 32'hCAFE, 16'h0000, 2'd0};
      tbl[7] = '{1'b0, 1'b1, 32'h77,   16'h0F0F, 1'b1, 1'b1, 1'b1, 32'h77,   16'h0F0F, 2'd1};
      // flush: 0x77 issues, 0x55 is dropped, data held since CLEAR_DATA_ON_FLUSH=0
      tbl[8] = '{1'b1, 1'b1, 32'h55,   16'hAAAA, 1'b1, 1'b1, 1'b0, 32'h77,   16'h0000, 2'd0};
      tbl[9] = '{1'b0, 1'b0, 32'h0,    16'h0000, 1'b1, 1'b1, 1'b0, 32'h77,   16'h0000, 2'd0};

      // reset state
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
      tick();
      tick();
      chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
      chk_out("rst", 1'b0, 32'h0, 16'h0, 2'd0);
      reset = 1'b1;
      #1;
      chk("rel.in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
      tick();
      chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
         #1;
         chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_d, tbl[i].e_c, tbl[i].e_occ);
      end

`ifdef PIPE_STAGE_SKID_EN
      // back-pressure: A into M, B into S, C held upstream, then drain in order
      drive(1'b0, 1'b1, 32'hA, 16'h000A, 1'b1);
      tick();
      chk_out("sk1", 1'b1, 32'hA, 16'h000A, 2'd1);
      drive(1'b0, 1'b1, 32'hB, 16'h000B, 1'b0);
      #1;
      chk("sk2.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("sk2", 1'b1, 32'hA, 16'h000A, 2'd2);
      chk("sk2.in_ready_after", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b1, 32'hC, 16'h000C, 1'b0);
      tick();
      chk_out("sk3", 1'b1, 32'hA, 16'h000A, 2'd2);
      chk("sk3.in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b1, 32'hC, 16'h000C, 1'b1);
      tick();
      chk_out("sk4", 1'b1, 32'hB, 16'h000B, 2'd1);
      chk("sk4.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("sk5", 1'b1, 32'hC, 16'h000C, 2'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      chk_out("sk6", 1'b0, 32'hC, 16'h0000, 2'd0);

      // flush with both entries full
      drive(1'b0, 1'b1, 32'hD1, 16'h00D1, 1'b0);
      tick();
      drive(1'b0, 1'b1, 32'hD2, 16'h00D2, 1'b0);
      tick();
      chk_out("skf.full", 1'b1, 32'hD1, 16'h00D1, 2'd2);
      drive(1'b1, 1'b1, 32'h55, 16'h5555, 1'b0);
      tick();
      chk_out("skf", 1'b0, 32'hD1, 16'h0000, 2'd0);
      chk("skf.in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      chk_out("skf.after", 1'b0, 32'hD1, 16'h0000, 2'd0);
`else
      // non-skid back-pressure: in_ready follows out_ready combinationally, occupancy <= 1
      drive(1'b0, 1'b1, 32'hA, 16'h000A, 1'b1);
      tick();
      chk_out("ns1", 1'b1, 32'hA, 16'h000A, 2'd1);
      drive(1'b0, 1'b1, 32'hB, 16'h000B, 1'b0);
      #1;
      chk("ns2.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk_out("ns2", 1'b1, 32'hA, 16'h000A, 2'd1);
      tick();
      chk_out("ns3", 1'b1, 32'hA, 16'h000A, 2'd1);
      drive(1'b0, 1'b1, 32'hB, 16'h000B, 1'b1);
      #1;
      chk("ns4.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("ns4", 1'b1, 32'hB, 16'h000B, 2'd1);
      drive(1'b0, 1'b1, 32'hC, 16'h000C, 1'b1);
      tick();
      chk_out("ns5", 1'b1, 32'hC, 16'h000C, 2'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      chk_out("ns6", 1'b0, 32'hC, 16'h0000, 2'd0);

      // flush while stalled and full
      drive(1'b0, 1'b1, 32'hD1, 16'h00D1, 1'b1);
      tick();
      drive(1'b1, 1'b1, 32'h55, 16'h5555, 1'b0);
      tick();
      chk_out("nsf", 1'b0, 32'hD1, 16'h0000, 2'd0);
      chk("nsf.in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      chk_out("nsf.after", 1'b0, 32'hD1, 16'h0000, 2'd0);
`endif

      // asynchronous reset mid-stream with one word held
      drive(1'b0, 1'b1, 32'h99, 16'h0001, 1'b0);
      tick();
      chk_out("mr.pre", 1'b1, 32'h99, 16'h0001, 2'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_out("mr", 1'b0, 32'h0, 16'h0000, 2'd0);
      chk("mr.in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
      #2;
      reset = 1'b1;
      tick();
      chk("mr.rel_in_ready", {31'd0, in_ready}, 32'd1);
      chk_out("mr.rel", 1'b0, 32'h0, 16'h0000, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
